// File: rtl/bp_window_shifter.sv
// bp_window_shifter: parametrised base-pair window register.
// A DEPTH-deep window of BP_W-bit base pairs, shifted serially through a
// valid/ready handshake. It also supports parallel load, synchronous flush
// and fill tracking, and it registers every bp that falls off the window.
//
// Ports:
//   clk         system clock; all state updates on posedge
//   reset       asynchronous, active-low reset
//   in_bp       serial base-pair input
//   in_valid    in_bp is valid this cycle
//   in_ready    block accepts in_bp this cycle (combinational)
//   en          shift enable
//   dir         1: left shift, new bp at LSB (R path); 0: right shift, new bp at MSB (Q path)
//   load        parallel load request
//   load_data   parallel window value
//   flush       synchronous clear of window and fill
//   out         current window (registered)
//   fill        number of valid bps in window, saturating at DEPTH
//   full        fill == DEPTH (registered)
//   evict_bp    bp shifted out by the last accepted shift (registered)
//   evict_valid single-cycle pulse; evict_bp holds real data
module bp_window_shifter #(
  parameter int BP_W  = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BP_W-1:0]         in_bp,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    load,
  input  logic [BP_W*DEPTH-1:0]   load_data,
  input  logic                    flush,
  output logic [BP_W*DEPTH-1:0]   out,
  output logic [CNT_W-1:0]        fill,
  output logic                    full,
  output logic [BP_W-1:0]         evict_bp,
  output logic                    evict_valid
);

  localparam int               WIN_W   = BP_W * DEPTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIN_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             full_q, full_d;
  logic [BP_W-1:0]  evict_bp_q, evict_bp_d;
  logic             evict_valid_q, evict_valid_d;
  logic             accept;

  assign in_ready = en & ~load & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_d         = out_q;
    fill_d        = fill_q;
    full_d        = full_q;
    evict_bp_d    = evict_bp_q;
    evict_valid_d = 1'b0;

    if (flush) begin
      out_d  = '0;
      fill_d = '0;
      full_d = 1'b0;
    end else if (load) begin
      out_d  = load_data;
      fill_d = DEPTH_C;
      full_d = 1'b1;
    end else if (accept) begin
      if (dir) begin
        out_d      = {out_q[WIN_W-BP_W-1:0], in_bp};
        evict_bp_d = out_q[WIN_W-1 -: BP_W];
      end else begin
        out_d      = {in_bp, out_q[WIN_W-1:BP_W]};
        evict_bp_d = out_q[BP_W-1:0];
      end
      fill_d        = (fill_q == DEPTH_C) ? DEPTH_C : fill_q + 1'b1;
      full_d        = (fill_d == DEPTH_C);
      // Only a full window pushes out real data; otherwise the bp leaving is a reset zero.
      evict_valid_d = full_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q         <= '0;
      fill_q        <= '0;
      full_q        <= 1'b0;
      evict_bp_q    <= '0;
      evict_valid_q <= 1'b0;
    end else begin
      out_q         <= out_d;
      fill_q        <= fill_d;
      full_q        <= full_d;
      evict_bp_q    <= evict_bp_d;
      evict_valid_q <= evict_valid_d;
    end
  end

  assign out         = out_q;
  assign fill        = fill_q;
  assign full        = full_q;
  assign evict_bp    = evict_bp_q;
  assign evict_valid = evict_valid_q;

endmodule

// File: tb/tb_bp_window_shifter.sv
module tb_bp_window_shifter;

  localparam int BP_W  = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int WIN_W = BP_W * DEPTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [BP_W-1:0]  in_bp;
  logic             in_valid;
  logic             in_ready;
  logic             en;
  logic             dir;
  logic             load;
  logic [WIN_W-1:0] load_data;
  logic             flush;
  logic [WIN_W-1:0] out;
  logic [CNT_W-1:0] fill;
  logic             full;
  logic [BP_W-1:0]  evict_bp;
  logic             evict_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: window as an array of bps, index 0 is the most significant bp.
  int m_bp [DEPTH];
  int m_fill;
  int m_ev;
  bit m_evv;

  always #5 clk = ~clk;

  bp_window_shifter #(.BP_W(BP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_bp(in_bp), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .dir(dir), .load(load),
    .load_data(load_data), .flush(flush), .out(out), .fill(fill),
    .full(full), .evict_bp(evict_bp), .evict_valid(evict_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] m_pack();
    logic [WIN_W-1:0] v = '0;
    for (int i = 0; i < DEPTH; i++) v = (v << BP_W) | WIN_W'(m_bp[i]);
    return v;
  endfunction

  function automatic bit m_ready();
    return en && !load && !flush;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_bp[i] = 0;
    m_fill = 0; m_ev = 0; m_evv = 0;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic m_step();
    logic [WIN_W-1:0] ld;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_bp[i] = 0;
      m_fill = 0; m_evv = 0;
    end else if (load) begin
      ld = load_data;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        m_bp[i] = int'(ld % (1 << BP_W));
        ld = ld >> BP_W;
      end
      m_fill = DEPTH; m_evv = 0;
    end else if (in_valid && m_ready()) begin
      m_evv = (m_fill == DEPTH);
      if (dir) begin
        m_ev = m_bp[0];
        for (int i = 0; i < DEPTH - 1; i++) m_bp[i] = m_bp[i+1];
        m_bp[DEPTH-1] = int'(in_bp);
      end else begin
        m_ev = m_bp[DEPTH-1];
        for (int i = DEPTH - 1; i > 0; i--) m_bp[i] = m_bp[i-1];
        m_bp[0] = int'(in_bp);
      end
      m_fill = (m_fill + 1 > DEPTH) ? DEPTH : m_fill + 1;
    end else begin
      m_evv = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"}, 64'(out), 64'(m_pack()));
    check({tag, ".fill"}, 64'(fill), 64'(m_fill));
    check({tag, ".full"}, 64'(full), 64'(m_fill == DEPTH));
    check({tag, ".evict_bp"}, 64'(evict_bp), 64'(m_ev));
    check({tag, ".evict_valid"}, 64'(evict_valid), 64'(m_evv));
  endtask

  task automatic drive(input bit f, input bit l, input logic [WIN_W-1:0] ld,
                       input bit e, input bit v, input bit d, input logic [BP_W-1:0] b);
    flush = f; load = l; load_data = ld; en = e; in_valid = v; dir = d; in_bp = b;
  endtask

  // Checks in_ready before the edge, advances one edge, then checks all outputs.
  task automatic tick(input string tag);
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready()));
    @(posedge clk);
    m_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 0, 0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check_all("reset");
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] fill_seq [6];
    fill_seq[0] = 3'd1; fill_seq[1] = 3'd2; fill_seq[2] = 3'd2;
    fill_seq[3] = 3'd2; fill_seq[4] = 3'd3; fill_seq[5] = 3'd4;

    do_reset();

    // Fill left (R path), then one eviction.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, '0, 1, 1, 1, 3'(i));
      tick("r_fill");
      check("r_fill.evv0", 64'(evict_valid), 64'd0);
    end
    check("r_out", 64'(out), 64'(12'o1234));
    check("r_full", 64'({fill, full}), 64'({3'd4, 1'b1}));
    drive(0, 0, '0, 1, 1, 1, 3'd5);
    tick("r_evict");
    check("r_evict.lit", 64'({out, evict_bp, evict_valid}), 64'({12'o2345, 3'd1, 1'b1}));
    drive(0, 0, '0, 1, 0, 1, '0);
    tick("r_pulse_end");
    check("r_pulse_end.lit", 64'(evict_valid), 64'd0);

    // Fill right (Q path), then one eviction.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, '0, 1, 1, 0, 3'(i));
      tick("q_fill");
    end
    check("q_out", 64'({out, full}), 64'({12'o4321, 1'b1}));
    drive(0, 0, '0, 1, 1, 0, 3'd5);
    tick("q_evict");
    check("q_evict.lit", 64'({out, evict_bp, evict_valid}), 64'({12'o5432, 3'd1, 1'b1}));

    // Parallel load, then a right shift evicts the low bp.
    drive(0, 1, 12'o7654, 1, 1, 0, 3'd3);
    tick("load");
    check("load.lit", 64'({out, fill, evict_valid}), 64'({12'o7654, 3'd4, 1'b0}));
    drive(0, 0, '0, 1, 1, 0, 3'd1);
    tick("load_shift");
    check("load_shift.lit", 64'({out, evict_bp, evict_valid}), 64'({12'o1765, 3'd4, 1'b1}));

    // Flush wins over load and accept.
    drive(1, 1, 12'o7777, 1, 1, 1, 3'd6);
    #1;
    check("flush.in_ready", 64'(in_ready), 64'd0);
    tick("flush");
    check("flush.lit", 64'({out, fill, full}), 64'd0);

    // Disabled: input dropped, state holds.
    drive(0, 1, 12'o3615, 1, 0, 1, '0);
    tick("preload");
    drive(0, 0, '0, 0, 1, 1, 3'd7);
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      check("hold.lit", 64'({in_ready, out, fill}), 64'({1'b0, 12'o3615, 3'd4}));
    end

    // Stall mid-fill.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 2 || i == 3) drive(0, 0, '0, 1, 0, 1, '0);
      else drive(0, 0, '0, 1, 1, 1, 3'(i < 2 ? i + 1 : i - 1));
      tick("stall");
      check("stall.fill", 64'(fill), 64'(fill_seq[i]));
    end
    check("stall.out", 64'(out), 64'(12'o1234));

    // Asynchronous reset between edges while full with an accept pending.
    drive(0, 0, '0, 1, 1, 1, 3'd6);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_held");
    reset = 1'b1;
    tick("after_rst");
    check("after_rst.lit", 64'({out, fill}), 64'({12'o0006, 3'd1}));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(19) == 0, $urandom_range(14) == 0, WIN_W'($urandom),
            $urandom_range(3) != 0, $urandom_range(2) != 0, 1'($urandom),
            BP_W'($urandom));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_window_shifter.md
Name:
bp_window_shifter

Overview:
Parametrised base-pair window register for the alignment datapath. It generalises the fixed 4-bp query/reference shift register to any base-pair width and window depth. It adds a valid/ready input handshake, parallel load, flush, fill tracking, and a registered output for each evicted base pair so downstream stages can consume the bps that fall off the window. One instance serves the Q path (dir=0) and one serves the R path (dir=1).

Parameters:
BP_W, 3, bits per base-pair code
DEPTH, 4, window length in base pairs (must be at least 2)
CNT_W, 3, fill counter width (must be at least clog2(DEPTH+1))

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
in_bp  in  BP_W  serial base-pair input
in_valid  in  1  in_bp is valid this cycle
in_ready  out  1  block will accept in_bp this cycle (combinational)
en  in  1  shift enable
dir  in  1  1 = left shift with new bp at LSB (R); 0 = right shift with new bp at MSB (Q)
load  in  1  parallel load request
load_data  in  BP_W*DEPTH  parallel window value
flush  in  1  synchronous clear of window and fill
out  out  BP_W*DEPTH  current window (registered)
fill  out  CNT_W  number of valid bps in window, saturating at DEPTH
full  out  1  fill == DEPTH (registered)
evict_bp  out  BP_W  bp shifted out by last accepted shift (registered)
evict_valid  out  1  single-cycle pulse; evict_bp holds real data

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - out=0, fill=0, full=0, evict_bp=0, evict_valid=0.
  - Release is synchronous to clk.
- in_ready = en & ~load & ~flush.
- accept = in_valid & in_ready.
- Per-cycle priority is flush > load > accept > hold.
- flush:
  - out<=0, fill<=0, full<=0, evict_valid<=0.
  - evict_bp holds its value.
  - Input is not accepted.
- load:
  - out<=load_data, fill<=DEPTH, full<=1, evict_valid<=0.
  - Input is not accepted.
- accept with dir=1:
  - out <= {out[BP_W*DEPTH-BP_W-1:0], in_bp}
  - evict_bp <= out[BP_W*DEPTH-1 -: BP_W]
- accept with dir=0:
  - out <= {in_bp, out[BP_W*DEPTH-1:BP_W]}
  - evict_bp <= out[BP_W-1:0]
- On accept:
  - fill <= (fill==DEPTH) ? DEPTH : fill+1. fill saturates and never wraps.
  - full updates in the same edge as fill.
  - evict_valid <= 1 only if full was 1 before the edge; otherwise 0. Bps shifted out of a partially filled window are reset zeros, not data.
- No accept (en=0, or in_valid=0):
  - out, fill, full and evict_bp hold.
  - evict_valid <= 0.
- Latency: accepted bp is visible in out one cycle after the accepting edge. evict_bp/evict_valid update on that same edge.
- dir may change between any two accepts; fill and full are unaffected by a direction change.
- Back-to-back accepts every cycle are supported; evict_valid stays high on each cycle while full.
- in_valid without in_ready drops the bp. The upstream source must hold it until in_ready.
- All outputs come from registers except in_ready.

Test Plan:
- BP_W=3, DEPTH=4 throughout. Octal literals below give one digit per bp.
- Reset, then dir=1, en=1, in_bp 1,2,3,4 valid on consecutive cycles -> out=12'o1234, fill=4, full=1 after the 4th edge, evict_valid=0 throughout. Then in_bp=5 -> out=12'o2345, evict_bp=1, evict_valid=1 for one cycle.
- Reset, dir=0, in_bp 1,2,3,4 -> out=12'o4321, full=1. Then in_bp=5 -> out=12'o5432, evict_bp=1, evict_valid=1.
- load=1 with load_data=12'o7654 -> out=12'o7654, fill=4, evict_valid=0. Next cycle dir=0, in_bp=1 accepted -> out=12'o1765, evict_bp=4, evict_valid=1.
- load=1, flush=1 and in_valid=1 in the same cycle -> in_ready=0, out=0, fill=0, full=0. Separately, en=0 with in_valid=1 -> in_ready=0 and all state holds for 3 cycles.
- Stall mid-fill: 2 accepts, then in_valid=0 for 2 cycles, then 2 accepts (dir=1, bps 1,2,3,4) -> out=12'o1234, fill goes 1,2,2,2,3,4 on successive edges.
- Assert reset=0 between clock edges while full with an accept pending -> out, fill, full, evict_valid read 0 before the next posedge. No shift occurs until reset=1 and a following edge.
